// File: rtl/datapath_pepo.sv
// rtl/datapath_pepo.sv - ARM-style multi-cycle datapath: register file, shifter, ALU, flags, LSM list and byte RAM
//
// Purpose: executes one control word per clock. Holds IR, MAR, MDR, NZCV, the load/store-multiple
//          register list and a 256-byte little-endian memory with a MOV/MOC handshake.
// Ports:
//    CLK          clock, all state updates on the rising edge
//    RESET        synchronous active-high reset
//    cu_datapath  34-bit control word from the control unit
//    IR_OUT       instruction register contents
//    LSM_DETECT   IR[27:25] == 100 (load/store multiple)
//    LSM_END      LSM register list is empty
//    MOC          memory operation complete
//    COND         IR[31:28] evaluated against NZCV

module datapath_pepo_rf (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_we,
   input  logic [3:0]  i_ra,
   input  logic [3:0]  i_rb,
   input  logic [3:0]  i_rc,
   input  logic [31:0] i_wd,
   output logic [31:0] PA,
   output logic [31:0] PB,
   output logic [31:0] QS15
);
   logic [31:0] r_regs [16];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      end else if (i_we) begin
         r_regs[i_rc] <= i_wd;
      end
   end

   // Reads are asynchronous, so a same-cycle write is seen only after the edge.
   assign PA   = r_regs[i_ra];
   assign PB   = r_regs[i_rb];
   assign QS15 = r_regs[15];
endmodule

module datapath_pepo (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [33:0] cu_datapath,
   output logic [31:0] IR_OUT,
   output logic        LSM_DETECT,
   output logic        LSM_END,
   output logic        MOC,
   output logic        COND
);
   logic        w_rf_ld, w_ir_ld, w_mar_ld, w_mdr_ld, w_mem_rd, w_mov, w_mc_sel;
   logic        w_flags_ld, w_lsm_ld, w_lsm_dec;
   logic [1:0]  w_dtype, w_ma_sel, w_mb_sel, w_ra_sel, w_rb_sel, w_rc_sel;
   logic [3:0]  w_alu_op;

   assign w_rf_ld    = cu_datapath[33];
   assign w_ir_ld    = cu_datapath[32];
   assign w_mar_ld   = cu_datapath[31];
   assign w_mdr_ld   = cu_datapath[30];
   assign w_mem_rd   = cu_datapath[29];
   assign w_mov      = cu_datapath[28];
   assign w_dtype    = cu_datapath[27:26];
   assign w_ma_sel   = cu_datapath[25:24];
   assign w_mb_sel   = cu_datapath[23:22];
   assign w_alu_op   = cu_datapath[21:18];
   assign w_mc_sel   = cu_datapath[17];
   assign w_ra_sel   = cu_datapath[16:15];
   assign w_rb_sel   = cu_datapath[14:13];
   assign w_rc_sel   = cu_datapath[12:11];
   assign w_flags_ld = cu_datapath[10];
   assign w_lsm_ld   = cu_datapath[9];
   assign w_lsm_dec  = cu_datapath[8];

   logic [31:0] r_ir, r_mar, r_mdr;
   logic [3:0]  r_nzcv;
   logic [15:0] r_lsm;
   logic        r_moc;
   logic [7:0]  r_mem [256];

   logic [31:0] ALU_OUT, MA_OUT, MC_OUT;
   logic [31:0] w_pa, w_pb, w_qs15, w_mb, w_shift, w_mem_data;
   logic [3:0]  w_ra, w_rb, w_rc, w_lsm_idx;
   logic        w_shift_c, w_alu_c, w_alu_v;

   // Lowest set bit of the list; stays 0 for an empty list.
   always_comb begin
      w_lsm_idx = 4'd0;
      for (int i = 15; i >= 0; i--) if (r_lsm[i]) w_lsm_idx = 4'(i);
   end

   always_comb begin
      case (w_ra_sel)
         2'b00:   w_ra = r_ir[19:16];
         2'b01:   w_ra = r_ir[15:12];
         2'b10:   w_ra = 4'hF;
         default: w_ra = w_lsm_idx;
      endcase
      case (w_rb_sel)
         2'b00:   w_rb = r_ir[19:16];
         2'b01:   w_rb = r_ir[15:12];
         2'b10:   w_rb = 4'hF;
         default: w_rb = w_lsm_idx;
      endcase
      case (w_rc_sel)
         2'b00:   w_rc = r_ir[15:12];
         2'b01:   w_rc = 4'hF;
         2'b10:   w_rc = r_ir[19:16];
         default: w_rc = w_lsm_idx;
      endcase
   end

   datapath_pepo_rf RF (
      .i_clk   (CLK),
      .i_reset (RESET),
      .i_we    (w_rf_ld),
      .i_ra    (w_ra),
      .i_rb    (w_rb),
      .i_rc    (w_rc),
      .i_wd    (ALU_OUT),
      .PA      (w_pa),
      .PB      (w_pb),
      .QS15    (w_qs15)
   );

   // Shifter. Extended shifts carry the last bit shifted out in the extra bit.
   logic [4:0]  w_amt, w_rot;
   logic [31:0] w_imm, w_imm_rot, w_ror;
   logic [32:0] w_lsl_ext, w_lsr_ext, w_asr_ext;

   assign w_amt     = r_ir[11:7];
   assign w_rot     = {r_ir[11:8], 1'b0};
   assign w_imm     = {24'b0, r_ir[7:0]};
   assign w_imm_rot = (w_imm >> w_rot) | (w_imm << (6'd32 - {1'b0, w_rot}));
   assign w_ror     = (w_pb >> w_amt) | (w_pb << (6'd32 - {1'b0, w_amt}));
   assign w_lsl_ext = {1'b0, w_pb} << w_amt;
   assign w_lsr_ext = {w_pb, 1'b0} >> w_amt;
   assign w_asr_ext = $signed({w_pb, 1'b0}) >>> w_amt;

   always_comb begin
      w_shift   = w_pb;
      w_shift_c = r_nzcv[1];
      if (r_ir[27:26] == 2'b01) begin
         w_shift = {20'b0, r_ir[11:0]};
      end else if (r_ir[25]) begin
         w_shift = w_imm_rot;
         if (w_rot != 5'd0) w_shift_c = w_imm_rot[31];
      end else if (w_amt != 5'd0) begin
         case (r_ir[6:5])
            2'b00:   {w_shift_c, w_shift} = w_lsl_ext;
            2'b01:   {w_shift, w_shift_c} = w_lsr_ext;
            2'b10:   {w_shift, w_shift_c} = w_asr_ext;
            default: begin
               w_shift   = w_ror;
               w_shift_c = w_ror[31];
            end
         endcase
      end
   end

   always_comb begin
      case (w_ma_sel)
         2'b01:   MA_OUT = r_mdr;
         2'b10:   MA_OUT = 32'd0;
         default: MA_OUT = w_pa;
      endcase
      case (w_mb_sel)
         2'b00:   w_mb = w_pb;
         2'b01:   w_mb = w_shift;
         2'b10:   w_mb = 32'd4;
         default: w_mb = 32'd0;
      endcase
   end

   // ALU: every arithmetic op is x + y + cin with operands swapped/inverted as needed.
   logic [31:0] w_x, w_y, w_logic;
   logic        w_cin, w_arith;
   logic [32:0] w_sum;

   always_comb begin
      w_x     = MA_OUT;
      w_y     = w_mb;
      w_cin   = 1'b0;
      w_arith = 1'b1;
      w_logic = 32'd0;
      case (w_alu_op)
         4'h0, 4'h8: begin w_arith = 1'b0; w_logic = MA_OUT & w_mb;  end
         4'h1, 4'h9: begin w_arith = 1'b0; w_logic = MA_OUT ^ w_mb;  end
         4'h2, 4'hA: begin w_y = ~w_mb; w_cin = 1'b1; end
         4'h3:       begin w_x = w_mb; w_y = ~MA_OUT; w_cin = 1'b1; end
         4'h4, 4'hB: ;
         4'h5:       w_cin = r_nzcv[1];
         4'h6:       begin w_y = ~w_mb; w_cin = r_nzcv[1]; end
         4'h7:       begin w_x = w_mb; w_y = ~MA_OUT; w_cin = r_nzcv[1]; end
         4'hC:       begin w_arith = 1'b0; w_logic = MA_OUT | w_mb;  end
         4'hD:       begin w_arith = 1'b0; w_logic = w_mb;           end
         4'hE:       begin w_arith = 1'b0; w_logic = MA_OUT & ~w_mb; end
         default:    begin w_arith = 1'b0; w_logic = ~w_mb;          end
      endcase
   end

   assign w_sum   = {1'b0, w_x} + {1'b0, w_y} + {32'b0, w_cin};
   assign ALU_OUT = w_arith ? w_sum[31:0] : w_logic;
   assign w_alu_c = w_arith ? w_sum[32] : w_shift_c;
   assign w_alu_v = w_arith ? ((w_x[31] == w_y[31]) && (w_sum[31] != w_x[31])) : r_nzcv[0];

   // Memory: little-endian, addresses wrap within 256 bytes.
   logic [7:0] w_a0, w_a1, w_a2, w_a3;
   logic       w_wr_commit;

   assign w_a0 = r_mar[7:0];
   assign w_a1 = w_a0 + 8'd1;
   assign w_a2 = w_a0 + 8'd2;
   assign w_a3 = w_a0 + 8'd3;

   always_comb begin
      case (w_dtype)
         2'b00:   w_mem_data = {24'b0, r_mem[w_a0]};
         2'b01:   w_mem_data = {16'b0, r_mem[w_a1], r_mem[w_a0]};
         default: w_mem_data = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[w_a0]};
      endcase
   end

   assign MC_OUT = w_mc_sel ? w_mem_data : ALU_OUT;
   assign MOC    = w_mov & r_moc;
   // A write lands exactly once: on the edge where MOC goes high.
   assign w_wr_commit = w_mov & ~r_moc & ~w_mem_rd & ~RESET;

   always_ff @(posedge CLK) begin
      if (w_wr_commit) begin
         r_mem[w_a0] <= r_mdr[7:0];
         if (w_dtype != 2'b00) r_mem[w_a1] <= r_mdr[15:8];
         if (w_dtype[1]) begin
            r_mem[w_a2] <= r_mdr[23:16];
            r_mem[w_a3] <= r_mdr[31:24];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_ir   <= '0;
         r_mar  <= '0;
         r_mdr  <= '0;
         r_nzcv <= '0;
         r_lsm  <= '0;
         r_moc  <= 1'b0;
      end else begin
         r_moc <= w_mov;
         if (w_ir_ld)    r_ir   <= r_mdr;
         if (w_mar_ld)   r_mar  <= ALU_OUT;
         if (w_mdr_ld)   r_mdr  <= MC_OUT;
         if (w_flags_ld) r_nzcv <= {ALU_OUT[31], ALU_OUT == 32'd0, w_alu_c, w_alu_v};
         if (w_lsm_ld)       r_lsm <= r_ir[15:0];
         else if (w_lsm_dec) r_lsm <= r_lsm & (r_lsm - 16'd1);
      end
   end

   logic w_n, w_z, w_c, w_v;
   assign {w_n, w_z, w_c, w_v} = r_nzcv;

   always_comb begin
      case (r_ir[31:28])
         4'h0:    COND = w_z;
         4'h1:    COND = ~w_z;
         4'h2:    COND = w_c;
         4'h3:    COND = ~w_c;
         4'h4:    COND = w_n;
         4'h5:    COND = ~w_n;
         4'h6:    COND = w_v;
         4'h7:    COND = ~w_v;
         4'h8:    COND = w_c & ~w_z;
         4'h9:    COND = ~w_c | w_z;
         4'hA:    COND = (w_n == w_v);
         4'hB:    COND = (w_n != w_v);
         4'hC:    COND = ~w_z & (w_n == w_v);
         4'hD:    COND = w_z | (w_n != w_v);
         4'hE:    COND = 1'b1;
         default: COND = 1'b0;
      endcase
   end

   assign IR_OUT     = r_ir;
   assign LSM_DETECT = (r_ir[27:25] == 3'b100);
   assign LSM_END    = (r_lsm == 16'd0);

   logic [63:0] w_unused_bits;
   assign w_unused_bits = {w_qs15, r_mar[31:8], cu_datapath[7:0]};
endmodule

// File: tb/tb_datapath_pepo.sv
// tb/tb_datapath_pepo.sv - self-checking bench for datapath_pepo
module tb_datapath_pepo;
   typedef struct packed {
      logic       rf_ld, ir_ld, mar_ld, mdr_ld, mem_rw, mov;
      logic [1:0] dt, ma, mb;
      logic [3:0] op;
      logic       mc;
      logic [1:0] ra, rb, rc;
      logic       flags_ld, lsm_ld, lsm_dec;
      logic [7:0] rsv;
   } cw_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [33:0] cu_datapath;
   logic [31:0] IR_OUT;
   logic        LSM_DETECT, LSM_END, MOC, COND;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q [$];

   datapath_pepo DUT (
      .CLK         (CLK),
      .RESET       (RESET),
      .cu_datapath (cu_datapath),
      .IR_OUT      (IR_OUT),
      .LSM_DETECT  (LSM_DETECT),
      .LSM_END     (LSM_END),
      .MOC         (MOC),
      .COND        (COND)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // R15 <= 0, then shift-and-add one bit at a time using R0 == 1 (list empty -> LSM index 0).
   task automatic load_r15(input logic [31:0] v);
      cw_t w;
      w = '0; w.ma = 2'b10; w.mb = 2'b11; w.op = 4'h0; w.rc = 2'b01; w.rf_ld = 1'b1;
      cu_datapath = w; tick();
      for (int i = 31; i >= 0; i--) begin
         w = '0; w.ra = 2'b10; w.rb = 2'b10; w.op = 4'h4; w.rc = 2'b01; w.rf_ld = 1'b1;
         cu_datapath = w; tick();
         if (v[i]) begin
            w.rb = 2'b11;
            cu_datapath = w; tick();
         end
      end
      cu_datapath = '0;
   endtask

   task automatic prime_one();
      cw_t w;
      w = '0; w.mb = 2'b11; w.op = 4'hF; w.rc = 2'b01; w.rf_ld = 1'b1;
      cu_datapath = w; tick();
      w = '0; w.ma = 2'b10; w.rb = 2'b10; w.op = 4'h2; w.rc = 2'b11; w.rf_ld = 1'b1;
      cu_datapath = w; tick();
      cu_datapath = '0;
   endtask

   task automatic set_mar(input logic [31:0] a);
      cw_t w;
      load_r15(a);
      w = '0; w.ra = 2'b10; w.mb = 2'b11; w.op = 4'h4; w.mar_ld = 1'b1;
      cu_datapath = w; tick();
      cu_datapath = '0;
   endtask

   task automatic set_mdr(input logic [31:0] d);
      cw_t w;
      load_r15(d);
      w = '0; w.ra = 2'b10; w.mb = 2'b11; w.op = 4'h4; w.mdr_ld = 1'b1;
      cu_datapath = w; tick();
      cu_datapath = '0;
   endtask

   task automatic mem_write(input logic [7:0] a, input logic [31:0] d, input logic [1:0] dt);
      cw_t w;
      set_mar({24'b0, a});
      set_mdr(d);
      w = '0; w.mov = 1'b1; w.dt = dt;
      cu_datapath = w; tick(); tick();
      cu_datapath = '0; tick();
   endtask

   task automatic mem_read(input logic [7:0] a, input logic [1:0] dt,
                           output logic [31:0] d, output logic ok);
      cw_t w;
      set_mar({24'b0, a});
      ok = 1'b0;
      d  = '0;
      w = '0; w.mov = 1'b1; w.mem_rw = 1'b1; w.dt = dt; w.mc = 1'b1; w.mdr_ld = 1'b1;
      cu_datapath = w;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (MOC) begin
            ok = 1'b1;
            d  = DUT.MC_OUT;
            break;
         end
      end
      tick();
      cu_datapath = '0; tick();
   endtask

   task automatic load_ir(input logic [7:0] a, input logic [31:0] v);
      cw_t w;
      logic [31:0] d;
      logic ok;
      mem_write(a, v, 2'b10);
      mem_read(a, 2'b10, d, ok);
      w = '0; w.ir_ld = 1'b1;
      cu_datapath = w; tick();
      cu_datapath = '0; #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1; cu_datapath = '0;
      tick(); tick();
      RESET = 1'b0; #1;
      n_cmp++; if (DUT.RF.QS15 !== 32'd0) begin n_fail++; $display("FAIL reset_qs15: got %h want 0", DUT.RF.QS15); end
      n_cmp++; if (IR_OUT !== 32'd0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", IR_OUT); end
      n_cmp++; if (MOC !== 1'b0) begin n_fail++; $display("FAIL reset_moc: got %b want 0", MOC); end
      n_cmp++; if (LSM_END !== 1'b1) begin n_fail++; $display("FAIL reset_lsm_end: got %b want 1", LSM_END); end
      n_cmp++; if (LSM_DETECT !== 1'b0) begin n_fail++; $display("FAIL reset_lsm_detect: got %b want 0", LSM_DETECT); end
      n_cmp++; if (COND !== 1'b0) begin n_fail++; $display("FAIL reset_cond: got %b want 0", COND); end
   endtask

   task automatic test_pc_increment();
      cw_t w;
      logic [31:0] e;
      w = '0; w.ra = 2'b10; w.mb = 2'b10; w.op = 4'h4; w.rc = 2'b01; w.rf_ld = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         exp_q.push_back(32'(4 * i));
         cu_datapath = w; tick();
         e = exp_q.pop_front();
         n_cmp++; if (DUT.RF.QS15 !== e) begin n_fail++; $display("FAIL pc_inc: got %h want %h", DUT.RF.QS15, e); end
      end
      cu_datapath = '0;
   endtask

   task automatic test_mem_word();
      cw_t w;
      logic [31:0] d, e;
      logic ok;
      set_mar(32'd0);
      set_mdr(32'hE2811001);
      w = '0; w.mov = 1'b1; w.dt = 2'b10;
      cu_datapath = w; #1;
      n_cmp++; if (MOC !== 1'b0) begin n_fail++; $display("FAIL moc_before: got %b want 0", MOC); end
      tick();
      n_cmp++; if (MOC !== 1'b1) begin n_fail++; $display("FAIL moc_after: got %b want 1", MOC); end
      tick();
      cu_datapath = '0; #1;
      n_cmp++; if (MOC !== 1'b0) begin n_fail++; $display("FAIL moc_drop: got %b want 0", MOC); end
      tick();
      exp_q.push_back(32'hE2811001);
      mem_read(8'd0, 2'b10, d, ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || d !== e) begin n_fail++; $display("FAIL read_word: got %h ok=%b want %h", d, ok, e); end
      w = '0; w.ir_ld = 1'b1;
      cu_datapath = w; tick();
      cu_datapath = '0; #1;
      n_cmp++; if (IR_OUT !== 32'hE2811001) begin n_fail++; $display("FAIL ir_load: got %h want e2811001", IR_OUT); end
      n_cmp++; if (COND !== 1'b1) begin n_fail++; $display("FAIL cond_al: got %b want 1", COND); end
   endtask

   task automatic test_alu();
      cw_t w;
      logic [31:0] e;
      logic [31:0] tbl [16] = '{32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000002,
                                32'h00000000, 32'h00000001, 32'hFFFFFFFE, 32'h00000002,
                                32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000000,
                                32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFE};
      load_r15(32'd5);
      w = '0; w.ra = 2'b10; w.mb = 2'b11; w.op = 4'h4; w.rc = 2'b00; w.rf_ld = 1'b1;
      cu_datapath = w; tick();
      w = '0; w.ra = 2'b00; w.mb = 2'b01; w.op = 4'h4; w.rc = 2'b00; w.rf_ld = 1'b1;
      cu_datapath = w; #1;
      n_cmp++; if (DUT.RF.PA !== 32'd5) begin n_fail++; $display("FAIL read_old: got %h want 5", DUT.RF.PA); end
      exp_q.push_back(32'd6);
      tick();
      w = '0; cu_datapath = w; #1;
      e = exp_q.pop_front();
      n_cmp++; if (DUT.RF.PA !== e) begin n_fail++; $display("FAIL add_imm_r1: got %h want %h", DUT.RF.PA, e); end
      w = '0; w.mb = 2'b11; w.op = 4'hF; w.rc = 2'b01; w.rf_ld = 1'b1;
      cu_datapath = w; tick();
      w = '0; w.ra = 2'b10; w.mb = 2'b01; w.op = 4'h4; w.flags_ld = 1'b1;
      cu_datapath = w; tick();
      n_cmp++; if (DUT.r_nzcv !== 4'b0110) begin n_fail++; $display("FAIL flags_add_wrap: got %b want 0110", DUT.r_nzcv); end
      for (int k = 0; k < 16; k++) begin
         w = '0; w.ra = 2'b10; w.mb = 2'b01; w.op = 4'(k);
         exp_q.push_back(tbl[k]);
         cu_datapath = w; #1;
         e = exp_q.pop_front();
         n_cmp++; if (DUT.ALU_OUT !== e) begin n_fail++; $display("FAIL alu_op_%0d: got %h want %h", k, DUT.ALU_OUT, e); end
      end
      w = '0; w.ra = 2'b10; w.mb = 2'b01; w.op = 4'hA; w.flags_ld = 1'b1;
      cu_datapath = w; tick();
      n_cmp++; if (DUT.r_nzcv !== 4'b1010) begin n_fail++; $display("FAIL flags_cmp: got %b want 1010", DUT.r_nzcv); end
      load_r15(32'h7FFFFFFF);
      w = '0; w.ra = 2'b10; w.mb = 2'b01; w.op = 4'h4; w.flags_ld = 1'b1;
      cu_datapath = w; tick();
      n_cmp++; if (DUT.r_nzcv !== 4'b1001) begin n_fail++; $display("FAIL flags_ovf: got %b want 1001", DUT.r_nzcv); end
      w.op = 4'h8;
      cu_datapath = w; tick();
      n_cmp++; if (DUT.r_nzcv !== 4'b0001) begin n_fail++; $display("FAIL flags_tst: got %b want 0001", DUT.r_nzcv); end
      cu_datapath = '0;
   endtask

   task automatic test_mem_bytes();
      logic [31:0] d, e;
      logic ok;
      mem_write(8'd1, 32'h12345677, 2'b00);
      mem_write(8'd6, 32'hABCDBEEF, 2'b01);
      mem_write(8'd255, 32'h0000005A, 2'b00);
      exp_q.push_back(32'hE2817701);
      mem_read(8'd0, 2'b10, d, ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || d !== e) begin n_fail++; $display("FAIL byte_write_word: got %h want %h", d, e); end
      exp_q.push_back(32'h0000BEEF);
      mem_read(8'd6, 2'b01, d, ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || d !== e) begin n_fail++; $display("FAIL half_read: got %h want %h", d, e); end
      exp_q.push_back(32'h000000E2);
      mem_read(8'd3, 2'b00, d, ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || d !== e) begin n_fail++; $display("FAIL byte_read: got %h want %h", d, e); end
      exp_q.push_back(32'h0000015A);
      mem_read(8'd255, 2'b01, d, ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || d !== e) begin n_fail++; $display("FAIL half_wrap: got %h want %h", d, e); end
   endtask

   task automatic test_shifter();
      cw_t w;
      logic [31:0] e;
      load_ir(8'd16, 32'hE1A00180);
      load_r15(32'h20000010);
      w = '0; w.rb = 2'b10; w.mb = 2'b01; w.op = 4'hD; w.flags_ld = 1'b1;
      exp_q.push_back(32'h00000080);
      cu_datapath = w; #1;
      e = exp_q.pop_front();
      n_cmp++; if (DUT.ALU_OUT !== e) begin n_fail++; $display("FAIL lsl3: got %h want %h", DUT.ALU_OUT, e); end
      tick();
      n_cmp++; if (DUT.r_nzcv !== 4'b0011) begin n_fail++; $display("FAIL lsl_carry: got %b want 0011", DUT.r_nzcv); end
      load_ir(8'd20, 32'hE1A00241);
      load_r15(32'h80000018);
      w = '0; w.rb = 2'b10; w.mb = 2'b01; w.op = 4'hD;
      exp_q.push_back(32'hF8000001);
      cu_datapath = w; #1;
      e = exp_q.pop_front();
      n_cmp++; if (DUT.ALU_OUT !== e) begin n_fail++; $display("FAIL asr4: got %h want %h", DUT.ALU_OUT, e); end
      cu_datapath = '0;
   endtask

   task automatic test_lsm();
      cw_t w;
      logic [31:0] e;
      load_ir(8'd24, 32'hE8BD000A);
      n_cmp++; if (LSM_DETECT !== 1'b1) begin n_fail++; $display("FAIL lsm_detect: got %b want 1", LSM_DETECT); end
      exp_q.push_back(32'd1); exp_q.push_back(32'd3); exp_q.push_back(32'd0);
      w = '0; w.lsm_ld = 1'b1;
      cu_datapath = w; tick();
      e = exp_q.pop_front();
      n_cmp++; if ({28'b0, DUT.w_lsm_idx} !== e || LSM_END !== 1'b0) begin n_fail++; $display("FAIL lsm_load: got idx %0d end %b want idx %0d end 0", DUT.w_lsm_idx, LSM_END, e); end
      w = '0; w.lsm_dec = 1'b1;
      cu_datapath = w; tick();
      e = exp_q.pop_front();
      n_cmp++; if ({28'b0, DUT.w_lsm_idx} !== e) begin n_fail++; $display("FAIL lsm_dec1: got %0d want %0d", DUT.w_lsm_idx, e); end
      cu_datapath = w; tick();
      e = exp_q.pop_front();
      n_cmp++; if (LSM_END !== 1'b1 || {28'b0, DUT.w_lsm_idx} !== e) begin n_fail++; $display("FAIL lsm_dec2: got end %b idx %0d want end 1 idx 0", LSM_END, DUT.w_lsm_idx); end
      w = '0; w.lsm_ld = 1'b1; w.lsm_dec = 1'b1;
      cu_datapath = w; tick();
      n_cmp++; if (DUT.w_lsm_idx !== 4'd1 || LSM_END !== 1'b0) begin n_fail++; $display("FAIL lsm_ld_dec: got idx %0d end %b want idx 1 end 0", DUT.w_lsm_idx, LSM_END); end
      cu_datapath = '0;
   endtask

   task automatic test_reset_during_mov();
      cw_t w;
      w = '0; w.mov = 1'b1; w.mem_rw = 1'b1;
      cu_datapath = w; tick(); tick();
      n_cmp++; if (MOC !== 1'b1) begin n_fail++; $display("FAIL mov_hold: got %b want 1", MOC); end
      RESET = 1'b1; tick();
      n_cmp++; if (MOC !== 1'b0) begin n_fail++; $display("FAIL rst_moc: got %b want 0", MOC); end
      n_cmp++; if (DUT.RF.QS15 !== 32'd0 || IR_OUT !== 32'd0) begin n_fail++; $display("FAIL rst_regs: got r15 %h ir %h want 0 0", DUT.RF.QS15, IR_OUT); end
      n_cmp++; if (DUT.r_mar !== 32'd0 || DUT.r_mdr !== 32'd0 || DUT.r_nzcv !== 4'd0) begin n_fail++; $display("FAIL rst_mar_mdr_flags: got %h %h %b want 0", DUT.r_mar, DUT.r_mdr, DUT.r_nzcv); end
      n_cmp++; if (LSM_END !== 1'b1 || COND !== 1'b0) begin n_fail++; $display("FAIL rst_lsm_cond: got end %b cond %b want 1 0", LSM_END, COND); end
      RESET = 1'b0; cu_datapath = '0; tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      RESET = 1'b1;
      cu_datapath = '0;
      test_reset();
      test_pc_increment();
      prime_one();
      test_mem_word();
      test_alu();
      test_mem_bytes();
      test_shifter();
      test_lsm();
      test_reset_during_mov();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
